// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : shared encodings for the data-memory load/store unit    |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_lane : byte-lane steering, store replication, load extend     |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        aligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] rdata_raw,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    aligned   = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = BE_BYTE << off;
        wdata_rep = {4{wdata[7:0]}};
        aligned   = 1'b1;
      end
      SZ_HALF: begin
        be        = BE_HALF << off;
        wdata_rep = {2{wdata[15:0]}};
        aligned   = ~off[0];
      end
      SZ_WORD: begin
        be        = BE_WORD;
        wdata_rep = wdata;
        aligned   = (off == 2'b00);
      end
      default: ;
    endcase
  end

  // Word loads are always aligned, so the shift is a no-op for them.
  always_comb begin
    shifted = rdata_raw >> {ld_off, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = {{16{ld_sext & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_lsu : load/store unit with valid/ready bus and CPU stall     |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              bus_valid_q, bus_valid_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              ld_sext_q, ld_sext_d;

  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic        aligned;
  logic [31:0] ld_data;
  logic        req_any;
  logic        req_ok;

  lsu_lane u_lane (
    .size      (size),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .aligned   (aligned),
    .ld_size   (ld_size_q),
    .ld_off    (ld_off_q),
    .ld_sext   (ld_sext_q),
    .rdata_raw (bus_rdata),
    .ld_data   (ld_data)
  );

  assign req_any = mem_rd | mem_wr;
  assign req_ok  = (mem_rd ^ mem_wr) & aligned;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    ld_size_d   = ld_size_q;
    ld_off_d    = ld_off_q;
    ld_sext_d   = ld_sext_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_ok) begin
          state_d     = ST_REQ;
          bus_valid_d = 1'b1;
          bus_we_d    = mem_wr;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_be_d    = be;
          bus_wdata_d = wdata_rep;
          ld_size_d   = size;
          ld_off_d    = addr[1:0];
          ld_sext_d   = sign_ext;
        end else if (req_any) begin
          addr_err_d = 1'b1;
        end
      end
      ST_REQ: begin
        // A ready in the final allowed cycle still completes normally.
        if (bus_ready) begin
          state_d     = ST_DONE;
          bus_valid_d = 1'b0;
          if (!bus_we_q) rdata_d = ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          bus_valid_d = 1'b0;
          rdata_d     = '0;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      ld_size_q   <= SZ_BYTE;
      ld_off_q    <= '0;
      ld_sext_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_sext_q   <= ld_sext_d;
    end
  end

  assign stall     = ((state_q == ST_IDLE) & req_ok) | (state_q == ST_REQ);
  assign rdata     = rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_lsu : directed + random bench with a behavioural model    |
// | rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_dmem_lsu;

  localparam int TIMEOUT = 4;

  logic        clka = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, sign_ext, bus_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall, addr_err, bus_err, bus_valid, bus_we;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clka = ~clka;

  dmem_lsu #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) u_dut (
    .clka(clka), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .addr_err(addr_err), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_legal(input bit rd, input bit wr, input logic [1:0] sz,
                                     input logic [31:0] a);
    int n = 1 << sz;
    return (rd != wr) && (sz != 2'b11) && ((a % n) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    int m = ((1 << n) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sx,
                                             input logic [31:0] a, input logic [31:0] raw);
    int n = 1 << sz;
    longint v, m;
    v = longint'(raw) >> (8 * (a % 4));
    m = (64'sd1 <<< (8 * n)) - 64'sd1;
    v = v & m;
    if (sx && n < 4 && v[8*n-1]) v = v | ~m;
    return v[31:0];
  endfunction

  // One CPU memory instruction; request stays asserted through its DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input bit never, input logic [31:0] raw);
    bit ok;
    int n_req, stall_cycles;
    @(negedge clka);
    mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rdata = $urandom;
    ok = model_legal(rd, wr, sz, a);
    #1;
    check("accept_stall", stall, ok);
    check("accept_valid", bus_valid, 0);
    check("accept_bus_err", bus_err, 0);
    if (!ok) begin
      @(negedge clka);
      mem_rd = 1'b0; mem_wr = 1'b0;
      #1;
      check("addr_err", addr_err, 1);
      check("err_valid", bus_valid, 0);
      check("err_stall", stall, 0);
      check("err_rdata", rdata, exp_rdata);
      @(negedge clka); #1;
      check("addr_err_pulse", addr_err, 0);
      check("err_valid2", bus_valid, 0);
      return;
    end
    stall_cycles = int'(stall);
    n_req = never ? TIMEOUT : waits + 1;
    for (int i = 0; i < n_req; i++) begin
      @(negedge clka);
      bus_ready = !never && (i == waits);
      bus_rdata = (i == waits) ? raw : $urandom;
      #1;
      check("req_valid", bus_valid, 1);
      check("req_we", bus_we, wr);
      check("req_addr", bus_addr, {a[31:2], 2'b00});
      check("req_be", bus_be, model_be(sz, a));
      check("req_wdata", bus_wdata, model_wdata(sz, wd));
      stall_cycles += int'(stall);
    end
    @(negedge clka);
    bus_ready = 1'b0; bus_rdata = $urandom;
    if (never) exp_rdata = '0;
    else if (rd) exp_rdata = model_load(sz, sx, a, raw);
    #1;
    stall_cycles += int'(stall);
    check("done_valid", bus_valid, 0);
    check("done_bus_err", bus_err, never);
    check("done_addr_err", addr_err, 0);
    check("done_rdata", rdata, exp_rdata);
    check("stall_cycles", stall_cycles, never ? TIMEOUT + 1 : waits + 2);
  endtask

  task automatic idle_cycle();
    @(negedge clka);
    mem_rd = 1'b0; mem_wr = 1'b0; addr = $urandom; wdata = $urandom;
    #1;
    check("idle_stall", stall, 0);
    check("idle_valid", bus_valid, 0);
    check("idle_addr_err", addr_err, 0);
    check("idle_bus_err", bus_err, 0);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, bus_valid, 0);
    check({tag, "_we"}, bus_we, 0);
    check({tag, "_be"}, bus_be, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_bus_err"}, bus_err, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clka);
    @(negedge clka); #1;
    check_reset_state("reset");
    rst = 1'b0;

    access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    access(1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 0, 32'h8000_0000);
    check("byte_sext", rdata, 32'hFFFF_FF80);
    access(1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 0, 32'h8000_0000);
    check("byte_zext", rdata, 32'h0000_0080);
    access(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 3, 0, 32'h0);
    access(1, 0, 2'b10, 0, 32'h06, 32'h0, 0, 0, 32'h0);
    access(1, 1, 2'b10, 0, 32'h08, 32'h0, 0, 0, 32'h0);
    access(1, 0, 2'b01, 1, 32'h44, 32'h0, 0, 1, 32'h0);
    access(1, 0, 2'b10, 0, 32'h30, 32'h0, 1, 0, 32'hCAFEF00D);

    // Reset lands in the second wait cycle of a load.
    @(negedge clka);
    mem_rd = 1'b1; mem_wr = 1'b0; size = 2'b10; addr = 32'h40; bus_ready = 1'b0;
    #1; check("rst_accept_stall", stall, 1);
    @(negedge clka); #1; check("rst_req_valid", bus_valid, 1);
    @(negedge clka); rst = 1'b1;
    @(negedge clka); rst = 1'b0; mem_rd = 1'b0;
    exp_rdata = '0;
    #1;
    check_reset_state("midreq_rst");
    access(1, 0, 2'b01, 1, 32'h52, 32'h0, 2, 0, 32'h9ABC_1234);

    for (int k = 0; k < 300; k++) begin
      int sel;
      bit rd, wr, never;
      logic [1:0] sz;
      sel = $urandom_range(0, 19);
      rd = (sel < 10) || (sel == 19);
      wr = (sel >= 10);
      sz = 2'($urandom_range(0, 3));
      never = rd && !wr && ($urandom_range(0, 15) == 0);
      access(rd, wr, sz, 1'($urandom), $urandom, $urandom,
             $urandom_range(0, TIMEOUT - 1), never, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
